// File: rtl/prbs_pkg.sv
// Shared PRBS link definitions: transmitter FSM states, default sync word,
// PRBS-15 seed and feedback taps. Also used by pattern_detect and the PRBS checker.
package prbs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PATTERN = 2'd1,
        ST_PRBS    = 2'd2
    } tx_state_e;

    localparam logic [31:0] PATTERN_DEFAULT     = 32'hCCDDEEFF;
    localparam logic [14:0] PRBS15_SEED_DEFAULT = 15'h7FFF;

    // x^15 + x^14 + 1: feedback is lfsr[14] ^ lfsr[13]
    localparam int PRBS15_TAP_HI = 14;
    localparam int PRBS15_TAP_LO = 13;

endpackage

// File: rtl/prbs_pattern_tx_if.sv
// Control and serial-output bundle of the PRBS pattern transmitter.
interface prbs_pattern_tx_if;
    logic [2:0] n;
    logic       start;
    logic       stop;
    logic       data_out;
    logic       valid;
    logic       prbs_mode;
    logic       pattern_done;

    // master drives control and observes the serial stream
    modport master (
        output n, start, stop,
        input  data_out, valid, prbs_mode, pattern_done
    );

    // slave is the transmitter itself
    modport slave (
        input  n, start, stop,
        output data_out, valid, prbs_mode, pattern_done
    );
endinterface

// File: rtl/prbs_pattern_tx_lfsr.sv
// PRBS-15 Fibonacci LFSR (x^15 + x^14 + 1). Reused by the receiver-side checker.
// The seed must be non-zero or the register locks up at all zeros.
module prbs15_lfsr
    import prbs_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        en,
    input  logic [14:0] seed,
    output logic        bit_out
);
    logic [14:0] lfsr;

    // reset and load both restart the sequence from the seed; load beats en
    always_ff @(posedge clk) begin
        if (!rst || load) begin
            lfsr <= seed;
        end else if (en) begin
            lfsr <= {lfsr[13:0], lfsr[PRBS15_TAP_HI] ^ lfsr[PRBS15_TAP_LO]};
        end
    end

    assign bit_out = lfsr[14];
endmodule

// File: rtl/prbs_pattern_tx.sv
// Serial transmitter: n repetitions of a 32-bit sync word (MSB first),
// followed by a continuous PRBS-15 stream until stop.
module prbs_pattern_tx
    import prbs_pkg::*;
#(
    parameter logic [31:0] PATTERN = PATTERN_DEFAULT,
    parameter logic [14:0] SEED    = PRBS15_SEED_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    prbs_pattern_tx_if.slave   bus
);
    tx_state_e  state;
    logic [4:0] bit_cnt;
    logic [2:0] rep_cnt;
    logic       data_q, valid_q, prbs_q, done_q;
    logic       lfsr_bit;
    logic       lfsr_load;
    logic       lfsr_en;

    // the LFSR restarts on every accepted start and steps once per PRBS bit sent
    assign lfsr_load = (state == ST_IDLE) && bus.start;
    assign lfsr_en   = (state == ST_PRBS);

    prbs15_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (lfsr_load),
        .en      (lfsr_en),
        .seed    (SEED),
        .bit_out (lfsr_bit)
    );

    // FSM plus registered outputs; the bit for the current state is emitted at
    // the same edge that may leave it, so stop still lets that last bit out
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            rep_cnt <= '0;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            prbs_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            prbs_q  <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // stop is ignored here, so start always wins
                    if (bus.start) begin
                        bit_cnt <= '0;
                        if (bus.n != 3'd0) begin
                            rep_cnt <= bus.n;
                            state   <= ST_PATTERN;
                        end else begin
                            state   <= ST_PRBS;
                        end
                    end
                end
                ST_PATTERN: begin
                    data_q  <= PATTERN[5'd31 - bit_cnt];
                    valid_q <= 1'b1;
                    bit_cnt <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'd31) begin
                        rep_cnt <= rep_cnt - 3'd1;
                        if (rep_cnt == 3'd1) begin
                            done_q <= 1'b1;
                            state  <= ST_PRBS;
                        end
                    end
                    if (bus.stop) state <= ST_IDLE;
                end
                ST_PRBS: begin
                    data_q  <= lfsr_bit;
                    valid_q <= 1'b1;
                    prbs_q  <= 1'b1;
                    if (bus.stop) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.data_out     = data_q;
    assign bus.valid        = valid_q;
    assign bus.prbs_mode    = prbs_q;
    assign bus.pattern_done = done_q;
endmodule

// File: tb/tb_prbs_pattern_tx.sv
// Scoreboard bench for prbs_pattern_tx: each scenario pushes the expected
// per-cycle {data_out, valid, prbs_mode, pattern_done} and compares on negedge.
module tb_prbs_pattern_tx;

    typedef struct packed {
        logic d;
        logic v;
        logic pm;
        logic pd;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    prbs_pattern_tx_if bus ();

    prbs_pattern_tx #(
        .PATTERN (32'hCCDDEEFF),
        .SEED    (15'h7FFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    obs_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [14:0] ref_lfsr;
    logic [31:0] pat = 32'hCCDDEEFF;

    function automatic void push_idle(input int k);
        for (int i = 0; i < k; i++) exp_q.push_back('0);
    endfunction

    function automatic void push_pattern(input int reps);
        obs_t e;
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < 32; i++) begin
                e.d  = pat[31-i];
                e.v  = 1'b1;
                e.pm = 1'b0;
                e.pd = (r == reps - 1) && (i == 31);
                exp_q.push_back(e);
            end
    endfunction

    function automatic void prbs_reload();
        ref_lfsr = 15'h7FFF;
    endfunction

    function automatic void push_prbs(input int k);
        obs_t e;
        for (int i = 0; i < k; i++) begin
            e.d  = ref_lfsr[14];
            e.v  = 1'b1;
            e.pm = 1'b1;
            e.pd = 1'b0;
            exp_q.push_back(e);
            ref_lfsr = {ref_lfsr[13:0], ref_lfsr[14] ^ ref_lfsr[13]};
        end
    endfunction

    // advance one clock and fetch observed/expected for that cycle
    task automatic step(output obs_t got, output obs_t exp);
        @(posedge clk);
        @(negedge clk);
        got = {bus.data_out, bus.valid, bus.prbs_mode, bus.pattern_done};
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : obs_t'('0);
    endtask

    task automatic test_stop_from_prbs(input string tag);
        obs_t g, e;
        bus.stop = 1'b1;
        push_prbs(1);
        push_idle(2);
        for (int i = 0; i < 3; i++) begin
            step(g, e);
            bus.stop = 1'b0;
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL %s_stop[%0d]: got d/v/pm/pd=%b required %b", tag, i, g, e);
            end
        end
    endtask

    task automatic test_reset();
        obs_t g, e;
        rst = 1'b0; bus.start = 1'b1; bus.n = 3'd5; bus.stop = 1'b0;
        push_idle(3);
        for (int i = 0; i < 3; i++) begin
            step(g, e);
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL reset[%0d]: got %b required %b", i, g, e);
            end
        end
        rst = 1'b1; bus.start = 1'b0;
        push_idle(2);
        for (int i = 0; i < 2; i++) begin
            step(g, e);
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL reset_release[%0d]: got %b required %b", i, g, e);
            end
        end
    endtask

    task automatic test_pattern_n1();
        obs_t g, e;
        logic [15:0] sh = '0;
        bus.n = 3'd1; bus.start = 1'b1;
        push_idle(1);
        prbs_reload();
        for (int i = 0; i < 73; i++) begin
            step(g, e);
            if (i == 0) begin
                bus.start = 1'b0;
                bus.n = 3'd6;
                push_pattern(1);
                push_prbs(40);
            end
            if (i >= 33 && i < 49) sh = {sh[14:0], g.d};
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL pattern_n1[%0d]: got %b required %b", i, g, e);
            end
        end
        n_cmp++;
        if (sh !== 16'hFFFE) begin
            n_err++;
            $display("FAIL prbs_head: got %h required fffe", sh);
        end
        test_stop_from_prbs("pattern_n1");
    endtask

    task automatic test_back_to_back();
        obs_t g, e;
        int pd_cnt = 0;
        int v_cnt  = 0;
        // start and stop together in IDLE: start wins
        bus.n = 3'd3; bus.start = 1'b1; bus.stop = 1'b1;
        push_idle(1);
        prbs_reload();
        for (int i = 0; i < 105; i++) begin
            step(g, e);
            if (i == 0) begin
                bus.start = 1'b0;
                bus.stop = 1'b0;
                push_pattern(3);
                push_prbs(8);
            end else begin
                pd_cnt += int'(g.pd);
                v_cnt  += int'(g.v);
            end
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: got %b required %b", i, g, e);
            end
        end
        n_cmp++;
        if (pd_cnt != 1 || v_cnt != 104) begin
            n_err++;
            $display("FAIL back_to_back_gapless: got pd=%0d valid=%0d required pd=1 valid=104", pd_cnt, v_cnt);
        end
        test_stop_from_prbs("back_to_back");
    endtask

    task automatic test_prbs_n0();
        obs_t g, e;
        logic [31:0] head = '0;
        bus.n = 3'd0; bus.start = 1'b1;
        push_idle(1);
        step(g, e);
        bus.start = 1'b0;
        n_cmp++;
        if (g !== e) begin
            n_err++;
            $display("FAIL prbs_n0_start: got %b required %b", g, e);
        end
        prbs_reload();
        for (int i = 0; i < 32767 + 32; i++) begin
            push_prbs(1);
            step(g, e);
            if (i < 32) head[i] = g.d;
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL prbs_n0[%0d]: got %b required %b", i, g, e);
            end
            if (i >= 32767) begin
                n_cmp++;
                if (g.d !== head[i-32767]) begin
                    n_err++;
                    $display("FAIL prbs_period[%0d]: got %b required %b", i, g.d, head[i-32767]);
                end
            end
        end
        test_stop_from_prbs("prbs_n0");
    endtask

    task automatic test_stop_restart();
        obs_t g, e;
        bus.n = 3'd4; bus.start = 1'b1;
        push_idle(1);
        push_pattern(4);
        step(g, e);
        bus.start = 1'b0;
        n_cmp++;
        if (g !== e) begin
            n_err++;
            $display("FAIL stop_restart_start: got %b required %b", g, e);
        end
        for (int i = 0; i < 11; i++) begin
            if (i == 10) bus.stop = 1'b1;
            step(g, e);
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL stop_at_bit10[%0d]: got %b required %b", i, g, e);
            end
        end
        exp_q.delete();
        bus.stop = 1'b0; bus.start = 1'b1; bus.n = 3'd2;
        push_idle(1);
        prbs_reload();
        for (int i = 0; i < 71; i++) begin
            step(g, e);
            if (i == 0) begin
                bus.start = 1'b0;
                push_pattern(2);
                push_prbs(6);
            end
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL restart_n2[%0d]: got %b required %b", i, g, e);
            end
        end
        test_stop_from_prbs("restart");
    endtask

    task automatic test_reset_mid_prbs();
        obs_t g, e;
        bus.n = 3'd0; bus.start = 1'b1;
        push_idle(1);
        prbs_reload();
        for (int i = 0; i < 51; i++) begin
            step(g, e);
            if (i == 0) begin
                bus.start = 1'b0;
                push_prbs(50);
            end
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL pre_reset_prbs[%0d]: got %b required %b", i, g, e);
            end
        end
        rst = 1'b0; bus.start = 1'b1;
        push_idle(3);
        for (int i = 0; i < 3; i++) begin
            step(g, e);
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL mid_reset[%0d]: got %b required %b", i, g, e);
            end
        end
        rst = 1'b1;
        push_idle(1);
        prbs_reload();
        for (int i = 0; i < 41; i++) begin
            step(g, e);
            if (i == 0) begin
                bus.start = 1'b0;
                push_prbs(40);
            end
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL post_reset_prbs[%0d]: got %b required %b", i, g, e);
            end
        end
        test_stop_from_prbs("reset_mid");
    endtask

    task automatic test_start_during_pattern();
        obs_t g, e;
        bus.n = 3'd2; bus.start = 1'b1;
        push_idle(1);
        prbs_reload();
        for (int i = 0; i < 75; i++) begin
            step(g, e);
            if (i == 0) begin
                bus.start = 1'b0;
                push_pattern(2);
                push_prbs(10);
            end
            if (i == 5)  begin bus.start = 1'b1; bus.n = 3'd7; end
            if (i == 6)  bus.start = 1'b0;
            if (i == 40) begin bus.start = 1'b1; bus.n = 3'd1; end
            if (i == 41) begin bus.start = 1'b0; bus.n = 3'd0; end
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL start_in_pattern[%0d]: got %b required %b", i, g, e);
            end
        end
        test_stop_from_prbs("start_in_pattern");
    endtask

    initial begin
        bus.n = 3'd0; bus.start = 1'b0; bus.stop = 1'b0;
        test_reset();
        test_pattern_n1();
        test_back_to_back();
        test_stop_restart();
        test_reset_mid_prbs();
        test_start_during_pattern();
        test_prbs_n0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
